quadc_tx_source: RTL and testbench

Transmit-side counterpart of the quad-ADC capture interface. It emits four 8-bit sample lanes with `valid` and `sync` in the same format the capture block presents to the F-engine. Samples come from user logic through a valid/ready push port and a small FIFO. Used for loopback, emulation and F-engine bring-up without live ADCs. It sits in the `user_clk` domain, in place of or alongside the capture block output.

---
 rtl/quadc_tx_source.sv | 169 ++++++++++++++++
 tb/tb_quadc_tx_source.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadc_tx_source.sv
// Transmit-side quad-ADC sample source: a push FIFO feeds four 8-bit lanes with valid/sync framing.
// Optional build macro QUADC_TX_RAMP_EN adds a test_mode port that streams a counting ramp instead of FIFO data.
module quadc_tx_source #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int SYNC_CNT_BITS   = 16
) (
    input  logic                     user_clk,
    input  logic                     reset,
    input  logic [31:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     enable,
    input  logic                     arm,
    input  logic [SYNC_CNT_BITS-1:0] sync_period,
`ifdef QUADC_TX_RAMP_EN
    input  logic                     test_mode,
`endif
    output logic [7:0]               adc0_data,
    output logic [7:0]               adc1_data,
    output logic [7:0]               adc2_data,
    output logic [7:0]               adc3_data,
    output logic                     valid,
    output logic                     sync,
    output logic                     armed,
    output logic [15:0]              underflow_count
);
    // state   | meaning
    // S_IDLE  | no sync reference yet, sync never asserted
    // S_ARMED | next emitted sample carries sync and restarts the sample counter
    // S_RUN   | periodic sync every sync_period samples (0 = none)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [SYNC_CNT_BITS-1:0]   CNT_ONE    = SYNC_CNT_BITS'(1);

    logic [31:0]                mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       tm;
    logic                       emit;
    logic                       period_hit;
    state_t                     state;
    logic [SYNC_CNT_BITS-1:0]   sample_cnt;
    logic [31:0]                rd_word;

`ifdef QUADC_TX_RAMP_EN
    logic [7:0] ramp;
    assign tm = test_mode;
`else
    assign tm = 1'b0;
`endif

    assign full     = (count == COUNT_FULL);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = enable && !tm && !empty;
    assign emit     = pop || (enable && tm);
    assign rd_word  = mem[rd_ptr];

    // sync_period of zero disables periodic syncs rather than wrapping to all-ones
    assign period_hit = (sync_period != '0) && (sample_cnt == sync_period - CNT_ONE);

    always_ff @(posedge user_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            valid      <= 1'b0;
            sync       <= 1'b0;
            armed      <= 1'b0;
        end else begin
            valid <= emit;
            sync  <= 1'b0;
            if (emit) begin
                case (state)
                    S_ARMED: begin
                        sync       <= 1'b1;
                        sample_cnt <= '0;
                        state      <= S_RUN;
                    end
                    S_RUN: begin
                        if (period_hit) begin
                            sync       <= 1'b1;
                            sample_cnt <= '0;
                        end else begin
                            sample_cnt <= sample_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
            // a fresh arm wins over the ARMED->RUN step taken above
            if (arm) begin
                state <= S_ARMED;
            end
            armed <= arm || ((state == S_ARMED) && !emit);
        end
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            adc0_data       <= '0;
            adc1_data       <= '0;
            adc2_data       <= '0;
            adc3_data       <= '0;
            underflow_count <= '0;
`ifdef QUADC_TX_RAMP_EN
            ramp            <= '0;
`endif
        end else begin
            if (pop) begin
                adc0_data <= rd_word[7:0];
                adc1_data <= rd_word[15:8];
                adc2_data <= rd_word[23:16];
                adc3_data <= rd_word[31:24];
            end
`ifdef QUADC_TX_RAMP_EN
            else if (enable && tm) begin
                adc0_data <= ramp;
                adc1_data <= ramp + 8'd1;
                adc2_data <= ramp + 8'd2;
                adc3_data <= ramp + 8'd3;
                ramp      <= ramp + 8'd1;
            end
`endif
            if (enable && !tm && empty && (underflow_count != 16'hFFFF)) begin
                underflow_count <= underflow_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_quadc_tx_source.sv
// Bench for quadc_tx_source: queue-based reference model checked every cycle, plus directed literal checks.
// Build with QUADC_TX_RAMP_EN defined to also exercise the ramp test mode.
module tb_quadc_tx_source;
    logic        user_clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        enable;
    logic        arm;
    logic [15:0] sync_period;
`ifdef QUADC_TX_RAMP_EN
    logic        test_mode;
`endif
    logic [7:0]  adc0_data, adc1_data, adc2_data, adc3_data;
    logic        valid, sync, armed;
    logic [15:0] underflow_count;

    always #5 user_clk = ~user_clk;

    quadc_tx_source #(.FIFO_DEPTH_LOG2(4), .SYNC_CNT_BITS(16)) dut (
        .user_clk        (user_clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .enable          (enable),
        .arm             (arm),
        .sync_period     (sync_period),
`ifdef QUADC_TX_RAMP_EN
        .test_mode       (test_mode),
`endif
        .adc0_data       (adc0_data),
        .adc1_data       (adc1_data),
        .adc2_data       (adc2_data),
        .adc3_data       (adc3_data),
        .valid           (valid),
        .sync            (sync),
        .armed           (armed),
        .underflow_count (underflow_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b + 8'h30, b + 8'h20, b + 8'h10, b};
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] q[$];
    bit          m_on = 0;
    bit          m_pending, m_active;
    int          m_n;
    logic [7:0]  e_lane [4];
    bit          e_valid, e_sync;
    logic [15:0] e_uf;
    logic [7:0]  e_ramp;
    bit          tm_m, emit_m, full_m, empty_m;
    logic [31:0] w_m;

    always @(posedge user_clk) begin
        if (reset) begin
            q.delete();
            m_pending = 0;
            m_active  = 0;
            m_n       = 0;
            for (int k = 0; k < 4; k++) e_lane[k] = 8'h00;
            e_valid = 0;
            e_sync  = 0;
            e_uf    = 16'h0;
            e_ramp  = 8'h00;
            m_on    = 1;
        end else if (m_on) begin
            tm_m = 0;
`ifdef QUADC_TX_RAMP_EN
            tm_m = test_mode;
`endif
            full_m  = (q.size() == 16);
            empty_m = (q.size() == 0);
            emit_m  = 0;
            e_sync  = 0;
            if (enable && !tm_m && !empty_m) begin
                w_m = q.pop_front();
                for (int k = 0; k < 4; k++) e_lane[k] = w_m[8*k +: 8];
                emit_m = 1;
            end else if (enable && tm_m) begin
                for (int k = 0; k < 4; k++) e_lane[k] = e_ramp + 8'(k);
                e_ramp = e_ramp + 8'd1;
                emit_m = 1;
            end
            if (enable && !tm_m && empty_m && e_uf != 16'hFFFF) e_uf = e_uf + 16'd1;
            if (emit_m) begin
                if (m_pending) begin
                    e_sync    = 1;
                    m_n       = 1;
                    m_active  = 1;
                    m_pending = 0;
                end else if (m_active) begin
                    e_sync = (sync_period != 0) && ((m_n % int'(sync_period)) == 0);
                    m_n++;
                end
            end
            if (arm) m_pending = 1;
            e_valid = emit_m;
            if (in_valid && !full_m) q.push_back(in_data);
        end
        #1;
        if (m_on) begin
            chk("m_valid", valid, e_valid);
            chk("m_sync", sync, e_sync);
            chk("m_adc0", adc0_data, e_lane[0]);
            chk("m_adc1", adc1_data, e_lane[1]);
            chk("m_adc2", adc2_data, e_lane[2]);
            chk("m_adc3", adc3_data, e_lane[3]);
            chk("m_armed", armed, m_pending);
            chk("m_in_ready", in_ready, q.size() < 16);
            chk("m_underflow", underflow_count, e_uf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge user_clk);
        @(negedge user_clk);
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1;
            in_data  = word(i);
            tick();
        end
        in_valid = 0;
    endtask

    task automatic pulse_arm();
        arm = 1;
        tick();
        arm = 0;
    endtask

    int  k_acc;
    bit  acc;

    initial begin
        reset       = 1;
        in_data     = 32'h0;
        in_valid    = 0;
        enable      = 0;
        arm         = 0;
        sync_period = 16'd0;
`ifdef QUADC_TX_RAMP_EN
        test_mode   = 0;
`endif
        @(negedge user_clk);
        tick();
        chk("rst_valid", valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_armed", armed, 1'b0);
        chk("rst_uf", underflow_count, 16'd0);
        chk("rst_adc0", adc0_data, 8'h00);
        reset = 0;

        // streaming and underflow
        enable   = 1;
        in_valid = 1;
        in_data  = 32'h03020100;
        tick();
        in_data  = 32'h13121110;
        tick();
        chk("t1_valid0", valid, 1'b1);
        chk("t1_adc0_0", adc0_data, 8'h00);
        chk("t1_adc3_0", adc3_data, 8'h03);
        in_data  = 32'h23222120;
        tick();
        chk("t1_adc0_1", adc0_data, 8'h10);
        chk("t1_adc3_1", adc3_data, 8'h13);
        in_valid = 0;
        tick();
        chk("t1_valid2", valid, 1'b1);
        chk("t1_adc0_2", adc0_data, 8'h20);
        chk("t1_adc3_2", adc3_data, 8'h23);
        tick();
        chk("t1_valid_end", valid, 1'b0);
        chk("t1_uf_a", underflow_count, 16'd2);
        chk("t1_hold", adc0_data, 8'h20);
        tick();
        chk("t1_uf_b", underflow_count, 16'd3);
        enable = 0;

        // fill and drain
        do_reset();
        k_acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1;
            in_data  = word(k_acc);
            acc      = in_ready;
            tick();
            if (acc) k_acc++;
        end
        chk("t2_accepted", k_acc, 16);
        chk("t2_full", in_ready, 1'b0);
        enable = 1;
        for (int i = 0; i < 17; i++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                k_acc++;
                if (k_acc == 17) in_valid = 0;
                else in_data = word(k_acc);
            end
            chk("t2_valid", valid, 1'b1);
            chk("t2_adc0", adc0_data, 8'(i));
            chk("t2_adc3", adc3_data, 8'(i) + 8'h30);
        end
        in_valid = 0;
        enable   = 0;

        // periodic sync
        do_reset();
        sync_period = 16'd4;
        push_words(12);
        pulse_arm();
        chk("t3_armed", armed, 1'b1);
        enable = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t3_valid", valid, 1'b1);
            chk("t3_sync", sync, (i % 4) == 0);
            chk("t3_armed_off", armed, 1'b0);
        end
        enable = 0;

        // period edge cases
        do_reset();
        sync_period = 16'd0;
        push_words(10);
        pulse_arm();
        enable = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_p0_sync", sync, i == 0);
        end
        enable = 0;
        sync_period = 16'd1;
        push_words(5);
        pulse_arm();
        enable = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_p1_sync", sync, 1'b1);
        end
        enable = 0;

        // reset mid-stream
        do_reset();
        sync_period = 16'd3;
        push_words(8);
        pulse_arm();
        enable = 1;
        tick();
        tick();
        tick();
        reset = 1;
        tick();
        chk("t5_valid", valid, 1'b0);
        chk("t5_sync", sync, 1'b0);
        chk("t5_in_ready", in_ready, 1'b1);
        chk("t5_armed", armed, 1'b0);
        chk("t5_uf", underflow_count, 16'd0);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_stale", valid, 1'b0);
        end
        chk("t5_uf_after", underflow_count, 16'd4);
        enable = 0;

`ifdef QUADC_TX_RAMP_EN
        // ramp mode
        do_reset();
        push_words(3);
        test_mode = 1;
        enable    = 1;
        for (int i = 0; i < 260; i++) begin
            tick();
            chk("t6_valid", valid, 1'b1);
            chk("t6_adc0", adc0_data, 8'(i));
            chk("t6_adc3", adc3_data, 8'(i + 3));
        end
        test_mode = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_fifo_kept", adc0_data, 8'(i));
        end
        enable = 0;
`endif

        // randomized run against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = $urandom;
            enable   = ($urandom_range(0, 99) < 80);
            arm      = ($urandom_range(0, 99) < 3);
            reset    = ($urandom_range(0, 399) == 0);
            if ((m_pending || !m_active) && !arm && $urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 5))
                    0: sync_period = 16'd0;
                    1: sync_period = 16'd1;
                    2: sync_period = 16'd2;
                    3: sync_period = 16'd3;
                    4: sync_period = 16'd5;
                    default: sync_period = 16'd7;
                endcase
            end
`ifdef QUADC_TX_RAMP_EN
            if ($urandom_range(0, 49) == 0) test_mode = ~test_mode;
`endif
            tick();
        end
        reset    = 0;
        in_valid = 0;
        enable   = 0;
        arm      = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
